// File: rtl/mra_dram_sched.sv
// mra_dram_sched: round-robin AXI4 master scheduler for two DRAM readers and one writer.
module mra_dram_sched #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              req,
    input  logic [3*ADDR_WIDTH-1:0] req_addr,
    input  logic [23:0]             req_len,
    output logic [2:0]              gnt,
    output logic [2:0]              done,
    output logic                    err,
    output logic                    busy,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic [1:0]              rd_valid,
    output logic                    rd_last,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_ready,
    output logic [ID_WIDTH-1:0]     arid_m_inf,
    output logic [ADDR_WIDTH-1:0]   araddr_m_inf,
    output logic [7:0]              arlen_m_inf,
    output logic [2:0]              arsize_m_inf,
    output logic [1:0]              arburst_m_inf,
    output logic                    arvalid_m_inf,
    input  logic                    arready_m_inf,
    input  logic [ID_WIDTH-1:0]     rid_m_inf,
    input  logic [DATA_WIDTH-1:0]   rdata_m_inf,
    input  logic [1:0]              rresp_m_inf,
    input  logic                    rlast_m_inf,
    input  logic                    rvalid_m_inf,
    output logic                    rready_m_inf,
    output logic [ID_WIDTH-1:0]     awid_m_inf,
    output logic [ADDR_WIDTH-1:0]   awaddr_m_inf,
    output logic [2:0]              awsize_m_inf,
    output logic [1:0]              awburst_m_inf,
    output logic [7:0]              awlen_m_inf,
    output logic                    awvalid_m_inf,
    input  logic                    awready_m_inf,
    output logic [DATA_WIDTH-1:0]   wdata_m_inf,
    output logic                    wlast_m_inf,
    output logic                    wvalid_m_inf,
    input  logic                    wready_m_inf,
    input  logic [ID_WIDTH-1:0]     bid_m_inf,
    input  logic [1:0]              bresp_m_inf,
    input  logic                    bvalid_m_inf,
    output logic                    bready_m_inf
);
    typedef enum logic [2:0] {S_IDLE, S_AR, S_RD, S_AW, S_WR, S_B} state_t;

    state_t                r_state, w_next;
    logic [1:0]            r_ptr, r_own, w_off, w_sel;
    logic [2:0]            w_rot, w_sum, w_wrap, r_gnt, r_done;
    logic                  w_any, r_err, r_eflag, r_busy;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len, r_cnt, w_cnt_nxt;
    logic                  r_arvalid, r_rready, r_awvalid, r_wvalid, r_wlast, r_bready;
    logic                  w_unused;

    // Rotate req so the pointer position lands on bit 0, pick the first set bit, rotate back.
    always_comb begin
        w_rot  = (r_ptr == 2'd1) ? {req[0], req[2], req[1]} :
                 (r_ptr == 2'd2) ? {req[1], req[0], req[2]} : req;
        w_off  = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : 2'd2;
        w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
        w_wrap = w_sum - 3'd3;
        w_sel  = (w_sum >= 3'd3) ? w_wrap[1:0] : w_sum[1:0];
        w_any  = |req;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = (w_sel == 2'd2) ? S_AW : S_AR;
            S_AR:    if (arready_m_inf) w_next = S_RD;
            S_RD:    if (rvalid_m_inf && rlast_m_inf) w_next = S_IDLE;
            S_AW:    if (awready_m_inf) w_next = S_WR;
            S_WR:    if (wready_m_inf && r_cnt == r_len) w_next = S_B;
            S_B:     if (bvalid_m_inf) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        w_cnt_nxt = (r_state == S_AW) ? 8'd0 :
                    (r_state == S_WR && wready_m_inf) ? r_cnt + 8'd1 : r_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= 2'd0;
            r_own     <= 2'd0;
            r_addr    <= '0;
            r_len     <= 8'd0;
            r_cnt     <= 8'd0;
            r_eflag   <= 1'b0;
            r_gnt     <= 3'd0;
            r_done    <= 3'd0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_wlast   <= 1'b0;
            r_bready  <= 1'b0;
        end else begin
            r_gnt     <= 3'd0;
            r_done    <= 3'd0;
            r_err     <= 1'b0;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= w_next != S_IDLE;
            r_arvalid <= w_next == S_AR;
            r_rready  <= w_next == S_RD;
            r_awvalid <= w_next == S_AW;
            r_wvalid  <= w_next == S_WR;
            r_wlast   <= (w_next == S_WR) && (w_cnt_nxt == r_len);
            r_bready  <= w_next == S_B;
            if (r_state == S_IDLE && w_any) begin
                r_gnt   <= 3'b001 << w_sel;
                r_own   <= w_sel;
                r_ptr   <= (w_sel == 2'd2) ? 2'd0 : w_sel + 2'd1;
                r_addr  <= req_addr[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
                r_len   <= req_len[w_sel*8 +: 8];
                r_eflag <= 1'b0;
            end
            if (r_state == S_RD && rvalid_m_inf) begin
                r_eflag <= r_eflag | (rresp_m_inf != 2'b00);
                if (rlast_m_inf) begin
                    r_done <= 3'b001 << r_own;
                    r_err  <= r_eflag | (rresp_m_inf != 2'b00);
                end
            end
            if (r_state == S_B && bvalid_m_inf) begin
                r_done <= 3'b100;
                r_err  <= bresp_m_inf != 2'b00;
            end
        end
    end

    assign gnt           = r_gnt;
    assign done          = r_done;
    assign err           = r_err;
    assign busy          = r_busy;
    assign arid_m_inf    = '0;
    assign awid_m_inf    = '0;
    assign arsize_m_inf  = 3'b100;
    assign awsize_m_inf  = 3'b100;
    assign arburst_m_inf = 2'b01;
    assign awburst_m_inf = 2'b01;
    assign araddr_m_inf  = r_addr;
    assign awaddr_m_inf  = r_addr;
    assign arlen_m_inf   = r_len;
    assign awlen_m_inf   = r_len;
    assign arvalid_m_inf = r_arvalid;
    assign rready_m_inf  = r_rready;
    assign awvalid_m_inf = r_awvalid;
    assign wvalid_m_inf  = r_wvalid;
    assign wlast_m_inf   = r_wlast;
    assign bready_m_inf  = r_bready;
    assign wdata_m_inf   = wr_data;
    assign wr_ready      = r_wvalid & wready_m_inf;
    assign rd_data       = rdata_m_inf;
    assign rd_last       = rlast_m_inf;
    assign rd_valid      = {rvalid_m_inf & r_rready & (r_own == 2'd1),
                            rvalid_m_inf & r_rready & (r_own == 2'd0)};
    // Single outstanding transaction, so response IDs carry no information.
    assign w_unused      = ^{rid_m_inf, bid_m_inf};
endmodule

// File: tb/tb_mra_dram_sched.sv
// tb_mra_dram_sched: directed vector table plus reset-mid-burst sequence for mra_dram_sched.
module tb_mra_dram_sched;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   req = '0;
    logic [95:0]  req_addr = {32'h0002_0000, 32'h0000_3000, 32'h0000_1000};
    logic [23:0]  req_len = '0;
    logic [2:0]   gnt, done;
    logic         err, busy, rd_last, wr_ready;
    logic [127:0] rd_data, wr_data = '0, wdata;
    logic [1:0]   rd_valid;
    logic [3:0]   arid, awid;
    logic [31:0]  araddr, awaddr;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize;
    logic [1:0]   arburst, awburst;
    logic         arvalid, arready = 1'b0, rready, awvalid, awready = 1'b0;
    logic [127:0] rdata = '0;
    logic [1:0]   rresp = '0, bresp = '0;
    logic         rlast = 1'b0, rvalid = 1'b0;
    logic         wlast, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
    logic [31:0]  base [3] = '{32'h0000_1000, 32'h0000_3000, 32'h0002_0000};
    int           checks = 0, failures = 0;

    always #5 clk = ~clk;

    mra_dram_sched dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_len(req_len),
        .gnt(gnt), .done(done), .err(err), .busy(busy),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .wr_data(wr_data), .wr_ready(wr_ready),
        .arid_m_inf(arid), .araddr_m_inf(araddr), .arlen_m_inf(arlen), .arsize_m_inf(arsize),
        .arburst_m_inf(arburst), .arvalid_m_inf(arvalid), .arready_m_inf(arready),
        .rid_m_inf(4'h0), .rdata_m_inf(rdata), .rresp_m_inf(rresp), .rlast_m_inf(rlast),
        .rvalid_m_inf(rvalid), .rready_m_inf(rready),
        .awid_m_inf(awid), .awaddr_m_inf(awaddr), .awsize_m_inf(awsize), .awburst_m_inf(awburst),
        .awlen_m_inf(awlen), .awvalid_m_inf(awvalid), .awready_m_inf(awready),
        .wdata_m_inf(wdata), .wlast_m_inf(wlast), .wvalid_m_inf(wvalid), .wready_m_inf(wready),
        .bid_m_inf(4'h0), .bresp_m_inf(bresp), .bvalid_m_inf(bvalid), .bready_m_inf(bready)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One full transaction: raise req, check grant/address, act as the DRAM, check done/err.
    task automatic do_txn(input string nm, input logic [2:0] rq, input logic [7:0] len,
                          input int ar_dly, input int bad, input logic [15:0] wpat,
                          input logic [2:0] egnt, input bit eerr);
        int g, k, n, cyc;
        g = egnt[2] ? 2 : egnt[1] ? 1 : 0;
        @(negedge clk);
        req = rq;
        req_len = {3{len}};
        @(negedge clk);
        chk({nm, ":gnt"}, gnt, egnt);
        chk({nm, ":busy"}, busy, 1'b1);
        req = '0;
        if (g < 2) begin
            chk({nm, ":arvalid"}, arvalid, 1'b1);
            chk({nm, ":araddr"}, araddr, base[g]);
            chk({nm, ":arlen"}, arlen, len);
            repeat (ar_dly) @(negedge clk);
            if (ar_dly > 0) chk({nm, ":arvalid_hold"}, arvalid, 1'b1);
            arready = 1'b1;
            @(negedge clk);
            arready = 1'b0;
            n = 0;
            for (k = 0; k <= int'(len); k++) begin
                rvalid = 1'b1;
                rdata  = {4{32'(k) + 32'hD000_0000}};
                rlast  = (k == int'(len));
                rresp  = (k == bad) ? 2'b10 : 2'b00;
                #1;
                if (rd_valid == (2'b01 << g)) n++;
                if (k == 0) chk({nm, ":rd_data"}, rd_data, rdata);
                @(negedge clk);
            end
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
            chk({nm, ":rd_strobes"}, n, len + 1);
        end else begin
            chk({nm, ":awvalid"}, awvalid, 1'b1);
            chk({nm, ":awaddr"}, awaddr, base[2]);
            chk({nm, ":awlen"}, awlen, len);
            awready = 1'b1;
            @(negedge clk);
            awready = 1'b0;
            k = 0;
            n = 0;
            cyc = 0;
            while (k <= int'(len) && cyc < 64) begin
                wready  = wpat[cyc % 16];
                wr_data = {4{32'(k) + 32'hA000_0000}};
                #1;
                if (wvalid !== 1'b1 || wdata !== wr_data) n++;
                if (wready) begin
                    if (wr_ready !== 1'b1 || wlast !== (k == int'(len))) n++;
                    k++;
                end else if (wr_ready !== 1'b0) n++;
                @(negedge clk);
                cyc++;
            end
            wready = 1'b0;
            chk({nm, ":w_beats"}, k, len + 1);
            chk({nm, ":w_beat_errs"}, n, 0);
            chk({nm, ":bready"}, bready, 1'b1);
            @(negedge clk);
            chk({nm, ":bready_hold"}, bready, 1'b1);
            bvalid = 1'b1;
            @(negedge clk);
            bvalid = 1'b0;
        end
        chk({nm, ":done"}, done, egnt);
        chk({nm, ":err"}, err, eerr);
        chk({nm, ":idle"}, busy, 1'b0);
    endtask

    typedef struct {
        logic [2:0]  rq;
        logic [7:0]  len;
        int          ar_dly;
        int          bad;
        logic [15:0] wpat;
        logic [2:0]  egnt;
        bit          eerr;
    } vec_t;

    vec_t tv [10];

    initial begin
        // Pointer carries across rows; expected grants follow from ptr 0 after reset.
        tv[0] = '{3'b001, 8'd63, 3, -1, 16'hFFFF, 3'b001, 1'b0};
        tv[1] = '{3'b111, 8'd7,  0, -1, 16'hFFFF, 3'b010, 1'b0};
        tv[2] = '{3'b111, 8'd3,  0, -1, 16'h002D, 3'b100, 1'b0};
        tv[3] = '{3'b111, 8'd7,  1, -1, 16'hFFFF, 3'b001, 1'b0};
        tv[4] = '{3'b001, 8'd7,  0,  5, 16'hFFFF, 3'b001, 1'b1};
        tv[5] = '{3'b001, 8'd7,  0, -1, 16'hFFFF, 3'b001, 1'b0};
        tv[6] = '{3'b101, 8'd0,  0, -1, 16'hFFFF, 3'b100, 1'b0};
        tv[7] = '{3'b110, 8'd3,  2, -1, 16'hFFFF, 3'b010, 1'b0};
        tv[8] = '{3'b011, 8'd2,  0, -1, 16'hFFFF, 3'b001, 1'b0};
        tv[9] = '{3'b100, 8'd0,  0, -1, 16'h0006, 3'b100, 1'b0};
        repeat (2) @(negedge clk);
        chk("reset_outs", {busy, gnt, done, err, arvalid, rready, awvalid, wvalid, wlast, bready, rd_valid, wr_ready}, '0);
        chk("reset_addr", {araddr, awaddr, arlen, awlen}, '0);
        chk("axi_const", {arsize, arburst, awsize, awburst, arid, awid}, {3'b100, 2'b01, 3'b100, 2'b01, 8'h00});
        rst = 1'b0;
        for (int i = 0; i < 10; i++)
            do_txn($sformatf("v%0d", i), tv[i].rq, tv[i].len, tv[i].ar_dly, tv[i].bad, tv[i].wpat, tv[i].egnt, tv[i].eerr);
        // Reset during rd1 beat 10: pointer would otherwise sit at 2 and favour wr.
        @(negedge clk);
        req = 3'b010;
        req_len = {3{8'd15}};
        @(negedge clk);
        chk("rst_seq:gnt", gnt, 3'b010);
        req = '0;
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rvalid = 1'b1;
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        chk("rst_seq:outs", {busy, gnt, done, err, arvalid, rready, awvalid, wvalid, wlast, bready, rd_valid, wr_ready}, '0);
        chk("rst_seq:addr", {araddr, arlen}, '0);
        rvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_txn("rst_seq:after", 3'b110, 8'd1, 0, -1, 16'hFFFF, 3'b010, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mra_dram_sched.md
# mra_dram_sched

DRAM access scheduler for the MRA routing accelerator. It shares the single AXI4 master port between three internal requesters: location-map reader (rd0), weight-map reader (rd1) and routed-map writeback (wr). It arbitrates round-robin, issues one INCR burst at a time, and steers read beats to the owning reader and write beats from the writer. It sits between the MRA core datapath and the `*_m_inf` AXI pins.

## Interface
- ID_WIDTH, 4, AXI ID width
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 128, AXI data width; one beat = 16 bytes
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- req  in  3  per-requester request level; [0]=rd0, [1]=rd1, [2]=wr; held until matching gnt bit
- req_addr  in  3*ADDR_WIDTH  start byte address per requester, slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]; must be 16-byte aligned
- req_len  in  24  burst length minus 1 per requester, slice i = [i*8 +: 8]
- gnt  out  3  one-cycle one-hot pulse; addr/len latched on this cycle
- done  out  3  one-cycle one-hot pulse at transaction completion
- err  out  1  valid with done; 1 if any RRESP/BRESP of that transaction was nonzero
- busy  out  1  scheduler not IDLE
- rd_data  out  DATA_WIDTH  read beat; combinational from rdata_m_inf
- rd_valid  out  2  read beat strobe to rd0/rd1; rvalid_m_inf qualified by owner
- rd_last  out  1  rlast_m_inf pass-through
- wr_data  in  DATA_WIDTH  current write beat; writer must hold beat k stable until wr_ready
- wr_ready  out  1  write beat accepted this cycle; writer advances to beat k+1
- AXI AR: arid_m_inf out ID_WIDTH, araddr_m_inf out ADDR_WIDTH, arlen_m_inf out 8, arsize_m_inf out 3, arburst_m_inf out 2, arvalid_m_inf out 1, arready_m_inf in 1
- AXI R: rid_m_inf in ID_WIDTH, rdata_m_inf in DATA_WIDTH, rresp_m_inf in 2, rlast_m_inf in 1, rvalid_m_inf in 1, rready_m_inf out 1
- AXI AW: awid_m_inf out ID_WIDTH, awaddr_m_inf out ADDR_WIDTH, awsize_m_inf out 3, awburst_m_inf out 2, awlen_m_inf out 8, awvalid_m_inf out 1, awready_m_inf in 1
- AXI W: wdata_m_inf out DATA_WIDTH, wlast_m_inf out 1, wvalid_m_inf out 1, wready_m_inf in 1
- AXI B: bid_m_inf in ID_WIDTH, bresp_m_inf in 2, bvalid_m_inf in 1, bready_m_inf out 1

## Operation
- Constants: arid/awid = 0, arsize/awsize = 3'b100, arburst/awburst = 2'b01 (INCR).
- States: IDLE, AR, RD, AW, WR, B. One outstanding transaction.
- IDLE: if any req bit is set, grant the first set bit at or after pointer ptr (cyclic 0→1→2). Latch addr/len, pulse gnt, set ptr = granted+1 mod 3, go to AR (rd0/rd1) or AW (wr).
- AR: arvalid=1 with latched addr/len. On arready, go to RD.
- RD: rready=1. rd_valid[owner] = rvalid. OR rresp≠0 into an error flag. On rvalid&rlast, go to IDLE and pulse done[owner] and err next cycle.
- AW: awvalid=1. On awready, clear beat counter and go to WR.
- WR: wvalid=1, wdata=wr_data, wr_ready = wready. Counter increments per accepted beat. wlast = (counter==len). On wready&wlast, go to B.
- B: bready=1. On bvalid, err = (bresp≠0). Pulse done[2] and go to IDLE.
- ptr resets to 0, so rd0 has priority for the first grant.

## Timing
- Reset (async, immediate) values: state IDLE, ptr 0. All valids, readies, gnt, done, err, busy, wlast, rd_valid = 0. Addresses/lengths = 0. Reset mid-burst drops valids at once; the DRAM model is reset with the block.
- All AXI valid/ready outputs and address fields are registered, except: wr_ready, rd_valid, rd_data and rd_last, which are combinational from AXI inputs; and wdata, which is combinational from wr_data.
- req sampled at cycle T in IDLE. gnt and arvalid/awvalid are high at T+1.
- Read latency floor: addr handshake at T+1, first beat at T+2.
- done pulses the cycle after the final R/B handshake. State is IDLE in that same cycle, and new arbitration occurs on the following edge. Minimum 1 IDLE cycle between transactions.
- Requester must drop req by the cycle after gnt. A req still high in IDLE counts as a new request.
- len=0: single beat; wlast is asserted on the first W beat.
- A req change while busy is ignored until IDLE.
- rvalid outside RD is ignored (rready=0). bvalid outside B is ignored.

## Test plan
- Single read: req=001, addr0=0x1000, len0=63, arready delayed 3 cycles. Expect gnt=001 at T+1, araddr=0x1000, arlen=63, 64 rd_valid[0] strobes, done=001 with err=0.
- Round-robin: req=111 held, each requester re-raising after done. Expect grant order rd0, rd1, wr, rd0; ptr wraps from 2 to 0.
- Write: req=100, addr2=0x2_0000, len2=3, wready toggling 1,0,1,1,0,1. Expect 4 wr_ready pulses, wlast only on 4th accepted beat, bready held until bvalid, done=100.
- Single-beat write len=0: wlast asserted with first wvalid; AW→WR→B completes.
- Error: rresp=2'b10 on beat 5 of 8 → err=1 with done=001; next transaction err=0.
- Async reset asserted during RD beat 10: all outputs 0 immediately. After release, req=010 is granted first as rd1; ptr restarted at 0 with rd0 idle.
